// File: rtl/mux2_arb_pkg.sv
// Shared types and defaults for the two-requester packet arbiter.
// Grant state encodings and parameter defaults live here.
package mux2_arb_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BEATS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

endpackage

// File: rtl/mux2to1_w.sv
// DATA_W-wide 2:1 data mux; sel=0 passes a, sel=1 passes b.
module mux2to1_w
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester packet arbiter: round-robin between packets,
// grant held until last beat or MAX_BEATS transfers.
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              last_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              last_b,
    output logic              gnt_b,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t           state;
    state_t           state_nxt;
    logic             favour_b;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             cur_last;
    logic             cap;
    logic             done;

    always_comb begin
        out_valid = ((state == GRANT_A) && req_a)
                 || ((state == GRANT_B) && req_b);
        xfer     = out_valid && out_ready;
        gnt_a    = xfer && (state == GRANT_A);
        gnt_b    = xfer && (state == GRANT_B);
        cur_last = (state == GRANT_B) ? last_b : last_a;
        cap      = (cnt == CNT_W'(MAX_BEATS - 1));
        done     = xfer && (cur_last || cap);
        // Forced release: the capping beat was not a packet end.
        err_timeout = xfer && !cur_last && cap;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_a && req_b)
                    state_nxt = favour_b ? GRANT_B : GRANT_A;
                else if (req_a)
                    state_nxt = GRANT_A;
                else if (req_b)
                    state_nxt = GRANT_B;
            end
            GRANT_A: begin
                if (done)
                    state_nxt = req_b ? GRANT_B : IDLE;
            end
            GRANT_B: begin
                if (done)
                    state_nxt = req_a ? GRANT_A : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            favour_b <= 1'b0;
            sel      <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == GRANT_A)
                sel <= 1'b0;
            else if (state_nxt == GRANT_B)
                sel <= 1'b1;
            // Serving A makes B the favourite for the next contest.
            if (done)
                favour_b <= (state == GRANT_A);
            if (done || state == IDLE)
                cnt <= '0;
            else if (xfer && cnt != CNT_W'(MAX_BEATS))
                cnt <= cnt + CNT_W'(1);
        end
    end

    mux2to1_w #(
        .DATA_W (DATA_W)
    ) u_mux (
        .a   (data_a),
        .b   (data_b),
        .sel (sel),
        .y   (out_data)
    );

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter with a transfer scoreboard.
// Expected beats are queued at drive time and popped on each grant.
module tb_mux2_arbiter;
    import mux2_arb_pkg::*;

    localparam int DW = 8;
    localparam int MB = 16;

    typedef struct packed {
        logic          src;
        logic [DW-1:0] data;
        logic          tmo;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, last_a, gnt_a;
    logic          req_b, last_b, gnt_b;
    logic [DW-1:0] data_a, data_b, out_data;
    logic          out_valid, out_ready, sel, err_timeout;

    beat_t exp_q[$];
    beat_t e;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(
        .DATA_W    (DW),
        .MAX_BEATS (MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_a       (req_a),
        .data_a      (data_a),
        .last_a      (last_a),
        .gnt_a       (gnt_a),
        .req_b       (req_b),
        .data_b      (data_b),
        .last_b      (last_b),
        .gnt_b       (gnt_b),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .sel         (sel),
        .err_timeout (err_timeout)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_a     = 1'b0;
        req_b     = 1'b0;
        last_a    = 1'b0;
        last_b    = 1'b0;
        data_a    = '0;
        data_b    = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_inputs();
        exp_q.delete();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        req_a = 1'b1;
        req_b = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({out_valid, gnt_a, gnt_b, sel, err_timeout} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b ga=%b gb=%b sel=%b tmo=%b exp all 0",
                     out_valid, gnt_a, gnt_b, sel, err_timeout);
        end
        next_cycle();
        rst_n = 1'b1;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_single;
        do_reset();
        req_a  = 1'b1;
        data_a = 8'hA5;
        last_a = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_req_cycle: got out_valid=%b exp 0", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 1) data_a = 8'h5A;
            if (i != 1) exp_q.push_back(beat_t'{1'b0, data_a, 1'b0});
            @(negedge clk);
            n_cmp++;
            if ({out_valid, gnt_a, sel} !== ((i == 1) ? 3'b000 : 3'b110)) begin
                n_bad++;
                $display("FAIL single_cyc%0d: got v=%b ga=%b sel=%b exp v=ga=%b sel=0",
                         i, out_valid, gnt_a, sel, (i != 1));
            end
            if (gnt_a || gnt_b) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_single: got unexpected transfer data=%h exp none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({gnt_b, out_data, err_timeout} !== {e.src, e.data, e.tmo}) begin
                        n_bad++;
                        $display("FAIL sb_single: got src=%b data=%h tmo=%b exp src=%b data=%h tmo=%b",
                                 gnt_b, out_data, err_timeout, e.src, e.data, e.tmo);
                    end
                end
            end
            if (i == 2) req_a = 1'b0;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL single_drain: got %0d pending exp 0", exp_q.size());
        end
    endtask

    task automatic test_alternate;
        do_reset();
        req_a  = 1'b1;
        req_b  = 1'b1;
        last_a = 1'b1;
        last_b = 1'b1;
        @(negedge clk);
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            data_a = DW'(8'h10 + i);
            data_b = DW'(8'h20 + i);
            if (i == 5) req_a = 1'b0;
            exp_q.push_back(beat_t'{i[0], i[0] ? data_b : data_a, 1'b0});
            @(negedge clk);
            n_cmp++;
            if ((gnt_a ^ gnt_b) !== 1'b1) begin
                n_bad++;
                $display("FAIL alt_no_gap%0d: got ga=%b gb=%b exp one grant", i, gnt_a, gnt_b);
            end
            if (gnt_a || gnt_b) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_alt: got unexpected transfer data=%h exp none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({gnt_b, out_data, err_timeout} !== {e.src, e.data, e.tmo}) begin
                        n_bad++;
                        $display("FAIL sb_alt: got src=%b data=%h tmo=%b exp src=%b data=%h tmo=%b",
                                 gnt_b, out_data, err_timeout, e.src, e.data, e.tmo);
                    end
                end
            end
            next_cycle();
        end
        req_b = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL alt_end: got v=%b pending=%0d exp 0/0", out_valid, exp_q.size());
        end
        next_cycle();
    endtask

    task automatic test_hold;
        do_reset();
        req_a  = 1'b1;
        req_b  = 1'b1;
        last_b = 1'b1;
        data_b = 8'hB7;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                data_a = DW'(8'hC0 + i);
                last_a = (i == 2);
                exp_q.push_back(beat_t'{1'b0, data_a, 1'b0});
            end else begin
                req_a  = 1'b0;
                last_a = 1'b0;
                exp_q.push_back(beat_t'{1'b1, data_b, 1'b0});
            end
            @(negedge clk);
            n_cmp++;
            if ({sel, gnt_b} !== ((i < 3) ? 2'b00 : 2'b11)) begin
                n_bad++;
                $display("FAIL hold_cyc%0d: got sel=%b gb=%b exp sel=gb=%b",
                         i, sel, gnt_b, (i == 3));
            end
            if (gnt_a || gnt_b) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_hold: got unexpected transfer data=%h exp none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({gnt_b, out_data, err_timeout} !== {e.src, e.data, e.tmo}) begin
                        n_bad++;
                        $display("FAIL sb_hold: got src=%b data=%h tmo=%b exp src=%b data=%h tmo=%b",
                                 gnt_b, out_data, err_timeout, e.src, e.data, e.tmo);
                    end
                end
            end
            next_cycle();
        end
        req_b = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL hold_drain: got %0d pending exp 0", exp_q.size());
        end
    endtask

    task automatic test_stall;
        do_reset();
        req_a  = 1'b1;
        data_a = 8'h33;
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            out_ready = (i == 0 || i == 5);
            if (i == 1) data_a = 8'h44;
            last_a = (i == 5);
            if (out_ready) exp_q.push_back(beat_t'{1'b0, data_a, 1'b0});
            @(negedge clk);
            if (!out_ready) begin
                n_cmp++;
                if ({gnt_a, out_valid, sel, out_data} !== {3'b010, 8'h44}) begin
                    n_bad++;
                    $display("FAIL stall_cyc%0d: got ga=%b v=%b sel=%b d=%h exp 0 1 0 44",
                             i, gnt_a, out_valid, sel, out_data);
                end
            end
            if (gnt_a || gnt_b) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_stall: got unexpected transfer data=%h exp none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({gnt_b, out_data, err_timeout} !== {e.src, e.data, e.tmo}) begin
                        n_bad++;
                        $display("FAIL sb_stall: got src=%b data=%h tmo=%b exp src=%b data=%h tmo=%b",
                                 gnt_b, out_data, err_timeout, e.src, e.data, e.tmo);
                    end
                end
            end
            next_cycle();
        end
        req_a = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_drain: got %0d pending exp 0", exp_q.size());
        end
    endtask

    task automatic test_timeout;
        int sent;
        do_reset();
        sent   = 0;
        req_a  = 1'b1;
        req_b  = 1'b1;
        last_b = 1'b1;
        data_b = 8'hBB;
        next_cycle();
        for (int c = 0; c < 20 && sent < MB; c++) begin
            req_a  = (c != 4);
            data_a = DW'(8'h60 + c);
            if (req_a) begin
                exp_q.push_back(beat_t'{1'b0, data_a, sent == MB - 1});
                sent++;
            end
            @(negedge clk);
            n_cmp++;
            if (gnt_b !== 1'b0 || (!req_a && {out_valid, err_timeout} !== 2'b00)) begin
                n_bad++;
                $display("FAIL tmo_hold_c%0d: got gb=%b v=%b tmo=%b exp 0",
                         c, gnt_b, out_valid, err_timeout);
            end
            if (gnt_a || gnt_b) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_tmo: got unexpected transfer data=%h exp none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({gnt_b, out_data, err_timeout} !== {e.src, e.data, e.tmo}) begin
                        n_bad++;
                        $display("FAIL sb_tmo: got src=%b data=%h tmo=%b exp src=%b data=%h tmo=%b",
                                 gnt_b, out_data, err_timeout, e.src, e.data, e.tmo);
                    end
                end
            end
            next_cycle();
        end
        req_a = 1'b0;
        exp_q.push_back(beat_t'{1'b1, data_b, 1'b0});
        @(negedge clk);
        n_cmp++;
        if ({sel, gnt_b} !== 2'b11) begin
            n_bad++;
            $display("FAIL tmo_handover: got sel=%b gb=%b exp 1 1", sel, gnt_b);
        end
        if (gnt_a || gnt_b) begin
            n_cmp++;
            e = exp_q.pop_front();
            if ({gnt_b, out_data, err_timeout} !== {e.src, e.data, e.tmo}) begin
                n_bad++;
                $display("FAIL sb_tmo_b: got src=%b data=%h tmo=%b exp src=%b data=%h tmo=%b",
                         gnt_b, out_data, err_timeout, e.src, e.data, e.tmo);
            end
        end
        next_cycle();
        req_b = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL tmo_drain: got %0d pending exp 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req_b  = 1'b1;
        data_b = 8'h5B;
        next_cycle();
        exp_q.push_back(beat_t'{1'b1, data_b, 1'b0});
        for (int i = 0; i < 6; i++) begin
            case (i)
                1: begin rst_n = 1'b0; out_ready = 1'b0; end
                2: begin
                    req_a = 1'b1; last_a = 1'b1; last_b = 1'b1;
                    data_a = 8'hA1; data_b = 8'hB2; out_ready = 1'b1;
                end
                3: rst_n = 1'b1;
                4: exp_q.push_back(beat_t'{1'b0, data_a, 1'b0});
                5: begin req_a = 1'b0; exp_q.push_back(beat_t'{1'b1, data_b, 1'b0}); end
                default: ;
            endcase
            @(negedge clk);
            if (i == 2) begin
                n_cmp++;
                if ({out_valid, sel, gnt_a, gnt_b} !== 4'b0) begin
                    n_bad++;
                    $display("FAIL rstmid_in_reset: got v=%b sel=%b ga=%b gb=%b exp 0",
                             out_valid, sel, gnt_a, gnt_b);
                end
            end
            if (i == 3 || i == 4) begin
                n_cmp++;
                if ({out_valid, sel} !== ((i == 3) ? 2'b00 : 2'b10)) begin
                    n_bad++;
                    $display("FAIL rstmid_cyc%0d: got v=%b sel=%b exp v=%b sel=0",
                             i, out_valid, sel, (i == 4));
                end
            end
            if (gnt_a || gnt_b) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_rstmid: got unexpected transfer data=%h exp none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({gnt_b, out_data, err_timeout} !== {e.src, e.data, e.tmo}) begin
                        n_bad++;
                        $display("FAIL sb_rstmid: got src=%b data=%h tmo=%b exp src=%b data=%h tmo=%b",
                                 gnt_b, out_data, err_timeout, e.src, e.data, e.tmo);
                    end
                end
            end
            next_cycle();
        end
        req_b = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_end: got v=%b pending=%0d exp 0/0", out_valid, exp_q.size());
        end
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_hold();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion exp finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each data path.
REQ-002 SHALL have parameter MAX_BEATS, default 16: maximum accepted beats per grant before forced release.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-005 SHALL have port req_a, input, 1: requester A has a valid beat.
REQ-006 SHALL have port data_a, input, DATA_W: requester A beat data.
REQ-007 SHALL have port last_a, input, 1: the current A beat is the final beat of its packet.
REQ-008 SHALL have port gnt_a, output, 1: the A beat is consumed this cycle.
REQ-009 SHALL have ports req_b, data_b, last_b and gnt_b, with the same directions, widths and meanings as the A ports.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a valid beat.
REQ-011 SHALL have port out_data, output, DATA_W: the selected beat.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts a beat.
REQ-013 SHALL have port sel, output, 1: current mux select; 0 selects A, 1 selects B.
REQ-014 SHALL have port err_timeout, output, 1: one-cycle pulse on forced release.

Function
REQ-015 SHALL implement an FSM with states IDLE, GRANT_A and GRANT_B.
REQ-016 In IDLE, the block SHALL go to GRANT_A if only req_a is high, and to GRANT_B if only req_b is high.
REQ-017 In IDLE with both requests high, the block SHALL grant the requester not served last (round-robin pointer).
REQ-018 The grant decision SHALL take effect on the next clock, giving 1 cycle from request to first possible transfer.
REQ-019 sel SHALL be a registered output: 0 in GRANT_A, 1 in GRANT_B, and its previous value held in IDLE.
REQ-020 out_data SHALL equal data_a when sel is 0 and data_b when sel is 1, combinationally.
REQ-021 out_valid SHALL equal (GRANT_A and req_a) or (GRANT_B and req_b), and SHALL be 0 in IDLE.
REQ-022 A transfer SHALL occur when out_valid and out_ready are both high.
REQ-023 gnt_x SHALL be high exactly on transfer cycles of the granted requester.
REQ-024 The grant SHALL be held across cycles where the granted requester drops its request (bubble) without a last beat.
REQ-025 On a transfer with the granted last_x high, the pointer SHALL update to the served requester.
REQ-026 On such a last-beat transfer, the next state SHALL be the other requester's grant state if it is requesting, otherwise IDLE (zero-bubble handover).
REQ-027 A beat counter SHALL count transfers within the current grant, be cleared on each new grant, and saturate at MAX_BEATS.
REQ-028 When the MAX_BEATS-th transfer occurs without a last beat, the block SHALL release as in REQ-025/026 and pulse err_timeout for that cycle.
REQ-029 When out_ready is low, no state, counter or pointer change SHALL occur except entry from IDLE.

Reset
REQ-030 While rst_n is low at a clock edge, the block SHALL set state to IDLE, pointer to favour A, sel to 0, counter to 0 and err_timeout to 0.
REQ-031 Consequently, out_valid, gnt_a and gnt_b SHALL be 0 during reset.
REQ-032 Reset asserted mid-packet SHALL abandon the packet with no further gnt pulses.

Structure
REQ-033 State encodings (IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2) and the DATA_W and MAX_BEATS defaults SHALL reside in shared package mux2_arb_pkg.
REQ-034 The data path SHALL be one instance of sub-module mux2to1_w, a DATA_W-wide 2:1 mux with ports a, b, sel and y.
REQ-035 The FSM, pointer and counter SHALL reside in mux2_arbiter.

Verification
REQ-036 Bench SHALL cover: reset, then req_a=1 with data_a=8'hA5, last_a=1 and out_ready=1 -> cycle 2 out_valid=1, out_data=A5, gnt_a=1, sel=0; then IDLE.
REQ-037 Bench SHALL cover: both requesting single-beat packets continuously with out_ready=1 -> grants alternate A, B, A, B with no idle cycle between them.
REQ-038 Bench SHALL cover: A sends a 3-beat packet while req_b=1 -> B is not granted until after A's last beat, then sel=1 on the next cycle.
REQ-039 Bench SHALL cover: out_ready=0 for 4 cycles mid-packet -> gnt_a=0, out_data stable, and state unchanged.
REQ-040 Bench SHALL cover: A holds last_a=0 for 16 transfers -> err_timeout=1 on the 16th transfer and grant passes to a requesting B.
REQ-041 Bench SHALL cover: rst_n=0 during GRANT_B -> next cycle out_valid=0, sel=0; after release, a simultaneous request grants A first.
